// File: rtl/seq_divider.sv
// 4-bit unsigned restoring divider, one quotient bit per clock (MSB first).
// Latency: 4 RUN cycles + 1 DONE cycle; start is accepted only in IDLE.
module seq_divider (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [3:0] a,
    input  logic [3:0] b,
    output logic [3:0] q,
    output logic [3:0] r,
    output logic       dz,
    output logic       busy,
    output logic       done
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t      r_state;
    state_t      w_state_nxt;

    logic [3:0]  r_a;
    logic [3:0]  r_b;
    logic [4:0]  r_rem;
    logic [3:0]  r_quo;
    logic [1:0]  r_cnt;
    logic [3:0]  r_q;
    logic [3:0]  r_r;
    logic        r_dz;

    logic [5:0]  w_shift;
    logic [4:0]  w_diff;
    logic        w_borrow;
    logic [4:0]  w_rem_nxt;
    logic [3:0]  w_quo_nxt;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        busy        = 1'b0;
        done        = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_state_nxt = (b == 4'd0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (r_cnt == 2'd3) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Partial remainder never reaches the divisor, so the top shifted bit is always zero;
    // it still takes part in the borrow compare to keep the step exact.
    always_comb begin
        w_shift   = {r_rem, r_a[3]};
        w_diff    = w_shift[4:0] - {1'b0, r_b};
        w_borrow  = (w_shift < {2'b00, r_b});
        w_rem_nxt = w_borrow ? w_shift[4:0] : w_diff;
        w_quo_nxt = {r_quo[2:0], ~w_borrow};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_a   <= 4'd0;
            r_b   <= 4'd0;
            r_rem <= 5'd0;
            r_quo <= 4'd0;
            r_cnt <= 2'd0;
            r_q   <= 4'd0;
            r_r   <= 4'd0;
            r_dz  <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (start) begin
                        if (b != 4'd0) begin
                            r_a   <= a;
                            r_b   <= b;
                            r_rem <= 5'd0;
                            r_quo <= 4'd0;
                            r_cnt <= 2'd0;
                        end else begin
                            r_q  <= 4'hF;
                            r_r  <= a;
                            r_dz <= 1'b1;
                        end
                    end
                end
                RUN: begin
                    r_a   <= {r_a[2:0], 1'b0};
                    r_rem <= w_rem_nxt;
                    r_quo <= w_quo_nxt;
                    r_cnt <= r_cnt + 2'd1;
                    // Final step: publish the result on the same edge that enters DONE.
                    if (r_cnt == 2'd3) begin
                        r_q  <= w_quo_nxt;
                        r_r  <= w_rem_nxt[3:0];
                        r_dz <= 1'b0;
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign q  = r_q;
    assign r  = r_r;
    assign dz = r_dz;

endmodule

// File: tb/tb_seq_divider.sv
// Directed self-checking bench for seq_divider; edge 1 is the edge that samples start.
module tb_seq_divider;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [3:0] a;
    logic [3:0] b;
    logic [3:0] q;
    logic [3:0] r;
    logic       dz;
    logic       busy;
    logic       done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    seq_divider dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .q     (q),
        .r     (r),
        .dz    (dz),
        .busy  (busy),
        .done  (done)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Pulse start with the given operands and wait (bounded) for done.
    task automatic run_op(input logic [3:0] ta, input logic [3:0] tb_v,
                          output int edges, output logic got);
        a     = ta;
        b     = tb_v;
        start = 1'b1;
        edges = 0;
        got   = 1'b0;
        while (!got && edges < 20) begin
            step();
            start = 1'b0;
            edges++;
            got = (done === 1'b1);
        end
    endtask

    initial begin
        int   edges;
        int   pulses;
        logic got;
        logic [3:0] cap_q;
        logic [3:0] cap_r;
        logic [3:0] ea;
        logic [3:0] eb;
        logic [3:0] exp_q;
        logic [3:0] exp_r;

        rst   = 1'b1;
        start = 1'b0;
        a     = 4'd0;
        b     = 4'd0;
        step();
        step();
        rst = 1'b0;
        chk("reset_q", {4'd0, q}, 8'd0);
        chk("reset_r", {4'd0, r}, 8'd0);
        chk("reset_dz", {7'd0, dz}, 8'd0);
        chk("reset_busy", {7'd0, busy}, 8'd0);
        chk("reset_done", {7'd0, done}, 8'd0);

        // 13 / 4: busy after edges 1-5, done only after edge 5
        a = 4'd13; b = 4'd4; start = 1'b1;
        step();
        start = 1'b0;
        chk("t1_busy_e1", {7'd0, busy}, 8'd1);
        chk("t1_done_e1", {7'd0, done}, 8'd0);
        for (int e = 2; e <= 4; e++) begin
            step();
            chk("t1_busy_run", {7'd0, busy}, 8'd1);
            chk("t1_done_run", {7'd0, done}, 8'd0);
        end
        step();
        chk("t1_done_e5", {7'd0, done}, 8'd1);
        chk("t1_busy_e5", {7'd0, busy}, 8'd1);
        chk("t1_q", {4'd0, q}, 8'd3);
        chk("t1_r", {4'd0, r}, 8'd1);
        chk("t1_dz", {7'd0, dz}, 8'd0);
        step();
        chk("t1_done_e6", {7'd0, done}, 8'd0);
        chk("t1_busy_e6", {7'd0, busy}, 8'd0);
        chk("t1_q_hold", {4'd0, q}, 8'd3);

        // 15 / 1, then 3 / 7 started in the cycle right after done
        run_op(4'd15, 4'd1, edges, got);
        chk("t2a_got", {7'd0, got}, 8'd1);
        chk("t2a_q", {4'd0, q}, 8'd15);
        chk("t2a_r", {4'd0, r}, 8'd0);
        step();
        chk("t2_idle_busy", {7'd0, busy}, 8'd0);
        run_op(4'd3, 4'd7, edges, got);
        chk("t2b_got", {7'd0, got}, 8'd1);
        chk("t2b_latency", edges[7:0], 8'd5);
        chk("t2b_q", {4'd0, q}, 8'd0);
        chk("t2b_r", {4'd0, r}, 8'd3);
        step();

        // 9 / 0: immediate done with divide-by-zero result
        a = 4'd9; b = 4'd0; start = 1'b1;
        step();
        start = 1'b0;
        chk("t3_done_e1", {7'd0, done}, 8'd1);
        chk("t3_q", {4'd0, q}, 8'd15);
        chk("t3_r", {4'd0, r}, 8'd9);
        chk("t3_dz", {7'd0, dz}, 8'd1);
        step();
        chk("t3_busy_e2", {7'd0, busy}, 8'd0);
        chk("t3_done_e2", {7'd0, done}, 8'd0);

        // 14 / 3 with a stray start and operand change in the 2nd RUN cycle
        a = 4'd14; b = 4'd3; start = 1'b1;
        step();
        start = 1'b0;
        step();
        chk("t4_q_stable", {4'd0, q}, 8'd15);
        chk("t4_dz_stable", {7'd0, dz}, 8'd1);
        a = 4'd1; b = 4'd1; start = 1'b1;
        step();
        start = 1'b0;
        pulses = 0;
        cap_q  = 4'd0;
        cap_r  = 4'd0;
        for (int i = 0; i < 8; i++) begin
            step();
            if (done === 1'b1) begin
                pulses++;
                cap_q = q;
                cap_r = r;
            end
        end
        chk("t4_pulses", pulses[7:0], 8'd1);
        chk("t4_q", {4'd0, cap_q}, 8'd4);
        chk("t4_r", {4'd0, cap_r}, 8'd2);

        // 12 / 5 aborted by reset in the 3rd RUN cycle
        a = 4'd12; b = 4'd5; start = 1'b1;
        step();
        start = 1'b0;
        step();
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("t5_q_rst", {4'd0, q}, 8'd0);
        chk("t5_r_rst", {4'd0, r}, 8'd0);
        chk("t5_busy_rst", {7'd0, busy}, 8'd0);
        chk("t5_done_rst", {7'd0, done}, 8'd0);
        pulses = 0;
        for (int i = 0; i < 6; i++) begin
            step();
            if (done !== 1'b0) pulses++;
        end
        chk("t5_no_done", pulses[7:0], 8'd0);
        run_op(4'd12, 4'd5, edges, got);
        chk("t5_got", {7'd0, got}, 8'd1);
        chk("t5_q", {4'd0, q}, 8'd2);
        chk("t5_r", {4'd0, r}, 8'd2);
        step();

        // Exhaustive sweep against a golden quotient/remainder
        for (int ia = 0; ia < 16; ia++) begin
            for (int ib = 0; ib < 16; ib++) begin
                ea = ia[3:0];
                eb = ib[3:0];
                if (ib == 0) begin
                    exp_q = 4'hF;
                    exp_r = ea;
                end else begin
                    exp_q = ea / eb;
                    exp_r = ea % eb;
                end
                run_op(ea, eb, edges, got);
                chk("sweep_got", {7'd0, got}, 8'd1);
                chk("sweep_latency", edges[7:0], (ib == 0) ? 8'd1 : 8'd5);
                chk("sweep_q", {4'd0, q}, {4'd0, exp_q});
                chk("sweep_r", {4'd0, r}, {4'd0, exp_r});
                chk("sweep_dz", {7'd0, dz}, (ib == 0) ? 8'd1 : 8'd0);
                step();
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
